pifo_reg: RTL and testbench
===========================

Name: pifo_reg

Overview:
- Register-based Push-In First-Out (PIFO) priority queue holding up to 2^L2_MAX_SIZE entries of (rank, metadata).
- Entries are kept sorted by rank in a shift-register array, so the head is always the best-ranked entry (lowest rank for ORDER="MIN").
- Used as a small scheduler primitive in the switch datapath: the producer inserts, the scheduler removes the head.

Parameters:
- L2_MAX_SIZE, 3: log2 of capacity; depth N = 2^L2_MAX_SIZE (default 8).
- RANK_WIDTH, 8: rank width in bits, unsigned.
- META_WIDTH, 8: metadata width in bits, opaque payload.
- ORDER, "MIN": "MIN" puts the smallest rank at the head; "MAX" puts the largest rank at the head.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (rst=0 sampled on a rising edge resets).
- insert  input  1  push rank_in/meta_in this cycle.
- remove  input  1  pop the head entry this cycle.
- rank_in  input  RANK_WIDTH  rank of the entry being inserted.
- meta_in  input  META_WIDTH  metadata of the entry being inserted.
- rank_out  output  RANK_WIDTH  rank of the current head entry.
- meta_out  output  META_WIDTH  metadata of the current head entry.
- valid_out  output  1  high when the queue is non-empty (head valid).

Behaviour:
- State: N slots {valid, rank, meta}, where slot 0 is the head.
  - Invariant: valid slots are contiguous from slot 0.
  - Invariant: valid slots are sorted by ORDER.
- Reset (rst=0 at a clock edge): all valid bits cleared, all slot ranks and metadata cleared to 0. Reset has priority over insert and remove, including mid-operation.
- Outputs are driven combinationally from slot 0 state, so there are no output registers:
  - valid_out = slot0.valid.
  - rank_out/meta_out = slot0 contents when valid, otherwise 0.
- Latency: an insert or remove takes effect at the clock edge, and the result is visible on the outputs the following cycle. Both operations have single-cycle throughput and may be issued every cycle.
- Insert only (insert=1, remove=0):
  - Position p is the first slot that is either invalid, or valid with a rank that the new entry strictly beats.
    - "Strictly beats" means rank_in < rank for MIN, or rank_in > rank for MAX.
  - Slots p..N-2 shift down by one, and the new entry is written to slot p.
  - Equal ranks stay in FIFO order: a new entry goes behind existing entries of the same rank.
- Remove only (remove=1, insert=0): slots 1..N-1 shift up by one, and slot N-1 becomes invalid. A remove on an empty queue is ignored and causes no state change.
- Simultaneous insert and remove:
  - The head seen this cycle (the pre-insert slot 0) is popped.
  - The new entry is placed among the remaining entries using the same position rule, so the net occupancy is unchanged.
  - If the queue is empty, only the insert takes effect.
- Full queue (all N slots valid):
  - An insert without a remove is dropped: state is unchanged and no error is flagged.
  - An insert together with a remove is accepted and handled as above.
- No overflow or underflow indication is provided. Callers gate insert using their own occupancy tracking.
- Rank comparison is unsigned over the full RANK_WIDTH.

Test Plan:
- Reset, then idle -> valid_out=0, rank_out=0, meta_out=0.
- Insert (5, 0x10), then remove 2 cycles later -> valid_out=1, rank_out=5, meta_out=0x10 after the insert edge; valid_out=0 after the remove edge.
- Insert in consecutive-gap cycles (8,0x20), (87,0x30), (54,0x40), (76,0x50), (47,0x60), (68,0x70), (29,0x80) -> the head tracks the minimum (8 throughout, since 29 > 8); the queue holds 7 entries.
- Insert (98,0x90) together with remove -> entry 8/0x20 is popped and 98 is inserted; the head becomes 29/0x80 and occupancy stays 7.
- Seven spaced removes -> the head sequence is 29,47,54,68,76,87,98 with metadata 0x80,0x60,0x40,0x70,0x50,0x30,0x90; valid_out=0 afterwards, and one extra remove leaves it empty.
- Fill with 8 entries, then insert a ninth (rank 0) without remove -> dropped, head unchanged. Also insert two entries of equal rank 7 (meta 0xA1 then 0xA2) -> 0xA1 is popped first. Also assert rst=0 mid-stream -> empty next cycle.

Source files
------------

// File: rtl/pifo_reg.sv
// Register-array PIFO: sorted shift-register priority queue with single-cycle insert/remove.
// Slot 0 always holds the best-ranked entry; outputs are driven directly from slot 0.
module pifo_reg #(
    parameter int unsigned L2_MAX_SIZE = 3,
    parameter int unsigned RANK_WIDTH  = 8,
    parameter int unsigned META_WIDTH  = 8,
    parameter string       ORDER       = "MIN"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  insert,
    input  logic                  remove,
    input  logic [RANK_WIDTH-1:0] rank_in,
    input  logic [META_WIDTH-1:0] meta_in,
    output logic [RANK_WIDTH-1:0] rank_out,
    output logic [META_WIDTH-1:0] meta_out,
    output logic                  valid_out
);

    localparam int unsigned N     = 1 << L2_MAX_SIZE;
    localparam bit          IsMax = (ORDER == "MAX");

    logic                  r_valid [N];
    logic [RANK_WIDTH-1:0] r_rank  [N];
    logic [META_WIDTH-1:0] r_meta  [N];

    logic                  w_pop;
    logic                  w_do_insert;
    logic                  w_base_valid [N];
    logic [RANK_WIDTH-1:0] w_base_rank  [N];
    logic [META_WIDTH-1:0] w_base_meta  [N];
    logic                  w_goes       [N];
    logic                  w_nxt_valid  [N];
    logic [RANK_WIDTH-1:0] w_nxt_rank   [N];
    logic [META_WIDTH-1:0] w_nxt_meta   [N];

    // Pop first, then place the new entry into the post-pop array.
    always_comb begin
        w_pop = remove && r_valid[0];
        for (int i = 0; i < N - 1; i++) begin
            w_base_valid[i] = w_pop ? r_valid[i+1] : r_valid[i];
            w_base_rank[i]  = w_pop ? r_rank[i+1]  : r_rank[i];
            w_base_meta[i]  = w_pop ? r_meta[i+1]  : r_meta[i];
        end
        w_base_valid[N-1] = w_pop ? 1'b0 : r_valid[N-1];
        w_base_rank[N-1]  = w_pop ? '0   : r_rank[N-1];
        w_base_meta[N-1]  = w_pop ? '0   : r_meta[N-1];
    end

    // w_goes is monotonic over the sorted array: the first set bit is the insert position.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_goes[i] = !w_base_valid[i] ||
                        (IsMax ? (rank_in > w_base_rank[i]) : (rank_in < w_base_rank[i]));
        end
    end

    always_comb begin
        w_do_insert = insert && !w_base_valid[N-1];
        for (int i = 0; i < N; i++) begin
            w_nxt_valid[i] = w_base_valid[i];
            w_nxt_rank[i]  = w_base_rank[i];
            w_nxt_meta[i]  = w_base_meta[i];
        end
        if (w_do_insert && w_goes[0]) begin
            w_nxt_valid[0] = 1'b1;
            w_nxt_rank[0]  = rank_in;
            w_nxt_meta[0]  = meta_in;
        end
        for (int i = 1; i < N; i++) begin
            if (w_do_insert && w_goes[i]) begin
                if (!w_goes[i-1]) begin
                    w_nxt_valid[i] = 1'b1;
                    w_nxt_rank[i]  = rank_in;
                    w_nxt_meta[i]  = meta_in;
                end else begin
                    w_nxt_valid[i] = w_base_valid[i-1];
                    w_nxt_rank[i]  = w_base_rank[i-1];
                    w_nxt_meta[i]  = w_base_meta[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_valid[i] <= 1'b0;
                r_rank[i]  <= '0;
                r_meta[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_valid[i] <= w_nxt_valid[i];
                r_rank[i]  <= w_nxt_rank[i];
                r_meta[i]  <= w_nxt_meta[i];
            end
        end
    end

    assign valid_out = r_valid[0];
    assign rank_out  = r_valid[0] ? r_rank[0] : '0;
    assign meta_out  = r_valid[0] ? r_meta[0] : '0;

endmodule

// File: tb/tb_pifo_reg.sv
// Bench for pifo_reg: directed scenarios plus random traffic against a sorted-queue model.
module tb_pifo_reg;

    localparam int unsigned N = 8;

    typedef struct {
        logic [7:0] rank;
        logic [7:0] meta;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       insert;
    logic       remove;
    logic [7:0] rank_in;
    logic [7:0] meta_in;
    logic [7:0] rank_out;
    logic [7:0] meta_out;
    logic       valid_out;

    ent_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pifo_reg #(
        .L2_MAX_SIZE(3),
        .RANK_WIDTH (8),
        .META_WIDTH (8),
        .ORDER      ("MIN")
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .insert   (insert),
        .remove   (remove),
        .rank_in  (rank_in),
        .meta_in  (meta_in),
        .rank_out (rank_out),
        .meta_out (meta_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a queue kept sorted; new entries go behind all entries of equal or better rank.
    task automatic model_step(input bit rn, input bit ins, input bit rem,
                              input logic [7:0] rk, input logic [7:0] mt);
        ent_t e;
        int   p;
        if (!rn) begin
            q.delete();
        end else begin
            if (rem && q.size() > 0) void'(q.pop_front());
            if (ins && q.size() < N) begin
                e.rank = rk;
                e.meta = mt;
                p = q.size();
                for (int j = 0; j < q.size(); j++) begin
                    if (rk < q[j].rank) begin
                        p = j;
                        break;
                    end
                end
                q.insert(p, e);
            end
        end
    endtask

    task automatic compare_head(input string tag);
        check({tag, "_valid"}, {31'd0, valid_out}, {31'd0, q.size() > 0});
        check({tag, "_rank"}, {24'd0, rank_out}, {24'd0, (q.size() > 0) ? q[0].rank : 8'd0});
        check({tag, "_meta"}, {24'd0, meta_out}, {24'd0, (q.size() > 0) ? q[0].meta : 8'd0});
    endtask

    task automatic cycle(input string tag, input bit rn, input bit ins, input bit rem,
                         input logic [7:0] rk, input logic [7:0] mt);
        rst     = rn;
        insert  = ins;
        remove  = rem;
        rank_in = rk;
        meta_in = mt;
        @(posedge clk);
        model_step(rn, ins, rem, rk, mt);
        #1;
        compare_head(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    logic [7:0] plan_rank [7];
    logic [7:0] plan_meta [7];
    logic [7:0] pop_rank  [7];
    logic [7:0] pop_meta  [7];

    initial begin
        rst = 1'b0; insert = 1'b0; remove = 1'b0; rank_in = '0; meta_in = '0;
        plan_rank = '{8'd8, 8'd87, 8'd54, 8'd76, 8'd47, 8'd68, 8'd29};
        plan_meta = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        pop_rank  = '{8'd29, 8'd47, 8'd54, 8'd68, 8'd76, 8'd87, 8'd98};
        pop_meta  = '{8'h80, 8'h60, 8'h40, 8'h70, 8'h50, 8'h30, 8'h90};

        cycle("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        cycle("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        idle("idle");
        check("idle_valid_const", {31'd0, valid_out}, 32'd0);

        cycle("ins5", 1'b1, 1'b1, 1'b0, 8'd5, 8'h10);
        check("ins5_rank_const", {24'd0, rank_out}, 32'd5);
        check("ins5_meta_const", {24'd0, meta_out}, 32'h10);
        idle("gap");
        cycle("rem5", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
        check("rem5_valid_const", {31'd0, valid_out}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            cycle("seq_ins", 1'b1, 1'b1, 1'b0, plan_rank[i], plan_meta[i]);
            check("seq_head_const", {24'd0, rank_out}, 32'd8);
            idle("seq_gap");
        end
        check("seq_occupancy", q.size(), 32'd7);

        cycle("ins_rem", 1'b1, 1'b1, 1'b1, 8'd98, 8'h90);
        check("ins_rem_rank_const", {24'd0, rank_out}, 32'd29);
        check("ins_rem_meta_const", {24'd0, meta_out}, 32'h80);

        for (int i = 0; i < 7; i++) begin
            check("pop_seq_rank", {24'd0, rank_out}, {24'd0, pop_rank[i]});
            check("pop_seq_meta", {24'd0, meta_out}, {24'd0, pop_meta[i]});
            cycle("pop", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
            idle("pop_gap");
        end
        check("drained_valid_const", {31'd0, valid_out}, 32'd0);
        cycle("rem_empty", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);

        for (int i = 0; i < 8; i++) cycle("fill", 1'b1, 1'b1, 1'b0, 8'(17 - i), 8'(8'hB0 + i));
        check("full_head_const", {24'd0, rank_out}, 32'd10);
        cycle("full_drop", 1'b1, 1'b1, 1'b0, 8'd0, 8'hEE);
        check("full_drop_const", {24'd0, rank_out}, 32'd10);
        cycle("full_ins_rem", 1'b1, 1'b1, 1'b1, 8'd1, 8'hEF);
        check("full_ins_rem_const", {24'd0, rank_out}, 32'd1);

        cycle("mid_reset", 1'b0, 1'b1, 1'b1, 8'd3, 8'h33);
        check("mid_reset_const", {31'd0, valid_out}, 32'd0);

        cycle("tie_a", 1'b1, 1'b1, 1'b0, 8'd7, 8'hA1);
        cycle("tie_b", 1'b1, 1'b1, 1'b0, 8'd7, 8'hA2);
        check("tie_first_const", {24'd0, meta_out}, 32'hA1);
        cycle("tie_pop", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
        check("tie_second_const", {24'd0, meta_out}, 32'hA2);
        cycle("ins_rem_lone", 1'b1, 1'b1, 1'b1, 8'd9, 8'hC9);
        cycle("ins_rem_empty_clr", 1'b1, 1'b0, 1'b1, 8'd0, 8'd0);
        cycle("ins_rem_empty", 1'b1, 1'b1, 1'b1, 8'd4, 8'hC4);
        check("ins_rem_empty_const", {24'd0, rank_out}, 32'd4);

        for (int i = 0; i < 3000; i++) begin
            cycle("rand", ($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 9) < 4), 8'($urandom_range(0, 15)), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
